// File: rtl/model_config_mem.sv
`default_nettype none
// ============================================================================
// model_config_mem: forward/backward compute tables plus capability registers
// behind a fixed-latency read port. Optional: CONFIG_MEM_BOUNDS_CHECK_EN.
// Revision: 1.0
// ============================================================================
module model_config_mem #(
    parameter int DEPTH        = 64,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] config_mem_addr_i,
    input  logic        config_mem_read_valid_i,
    output logic [31:0] config_mem_read_data_o,
    output logic        config_mem_read_ready_o,
    input  logic        wr_valid_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    output logic        wr_ready_o,
    output logic [31:0] npu_capability_o,
    output logic [31:0] in_pipeline_cim_capability_o,
    output logic [31:0] bubble_threshold_o
`ifdef CONFIG_MEM_BOUNDS_CHECK_EN
    ,
    output logic        rd_err_o
`endif
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_LAST = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wr_ready_q;
    logic [31:0] fwd_q [DEPTH];
    logic [31:0] fwd_d [DEPTH];
    logic [31:0] bwd_q [DEPTH];
    logic [31:0] bwd_d [DEPTH];
    logic [31:0] cap_q [3];
    logic [31:0] cap_d [3];
    logic [31:0] cap_addr;
    logic [31:0] lookup;

    // Location exists in the map and the upper address bits are clear.
    function automatic logic in_range(input logic [31:0] a);
        logic ok;
        unique case (a[9:8])
            2'd0, 2'd1: ok = ({24'd0, a[7:0]} < 32'(DEPTH));
            2'd2:       ok = (a[7:0] < 8'd3);
            default:    ok = 1'b0;
        endcase
        return ok && (a[31:10] == 22'd0);
    endfunction

    // With READ_LATENCY=1 capture coincides with acceptance, so use the live address.
    always_comb begin
        cap_addr = (state_q == S_IDLE) ? config_mem_addr_i : addr_q;
        lookup   = 32'd0;
        unique case (cap_addr[9:8])
            2'd0: lookup = fwd_q[cap_addr[IDX_W-1:0]];
            2'd1: lookup = bwd_q[cap_addr[IDX_W-1:0]];
            2'd2: begin
                unique case (cap_addr[7:0])
                    8'd0:    lookup = cap_q[0];
                    8'd1:    lookup = cap_q[1];
                    8'd2:    lookup = cap_q[2];
                    default: lookup = 32'd0;
                endcase
            end
            default: lookup = 32'd0;
        endcase
`ifdef CONFIG_MEM_BOUNDS_CHECK_EN
        if (!in_range(cap_addr)) begin
            lookup = 32'hDEAD_BEEF;
        end
`endif
    end

`ifndef CONFIG_MEM_BOUNDS_CHECK_EN
    logic unused_addr_hi;
    assign unused_addr_hi = ^cap_addr[31:10];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (config_mem_read_valid_i) begin
                    addr_d = config_mem_addr_i;
                    if (READ_LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q >= LAT_LAST) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (state_d == S_RESP) begin
            rdata_d = lookup;
        end
    end

    always_comb begin
        fwd_d = fwd_q;
        bwd_d = bwd_q;
        cap_d = cap_q;
        if (wr_valid_i && in_range(wr_addr_i)) begin
            unique case (wr_addr_i[9:8])
                2'd0: fwd_d[wr_addr_i[IDX_W-1:0]] = wr_data_i;
                2'd1: bwd_d[wr_addr_i[IDX_W-1:0]] = wr_data_i;
                2'd2: begin
                    unique case (wr_addr_i[7:0])
                        8'd0:    cap_d[0] = wr_data_i;
                        8'd1:    cap_d[1] = wr_data_i;
                        8'd2:    cap_d[2] = wr_data_i;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 32'd0;
            rdata_q    <= 32'd0;
            wr_ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fwd_q[i] <= 32'd0;
                bwd_q[i] <= 32'd0;
            end
            cap_q[0] <= 32'd1;
            cap_q[1] <= 32'd1;
            cap_q[2] <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            wr_ready_q <= 1'b1;
            fwd_q      <= fwd_d;
            bwd_q      <= bwd_d;
            cap_q      <= cap_d;
        end
    end

`ifdef CONFIG_MEM_BOUNDS_CHECK_EN
    logic rd_err_q, rd_err_d;

    always_comb begin
        rd_err_d = 1'b0;
        if (state_d == S_RESP) begin
            rd_err_d = !in_range(cap_addr);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_err_q <= 1'b0;
        end else begin
            rd_err_q <= rd_err_d;
        end
    end

    assign rd_err_o = rd_err_q;
`endif

    assign config_mem_read_data_o       = rdata_q;
    assign config_mem_read_ready_o      = (state_q == S_RESP);
    assign wr_ready_o                   = wr_ready_q;
    assign npu_capability_o             = cap_q[0];
    assign in_pipeline_cim_capability_o = cap_q[1];
    assign bubble_threshold_o           = cap_q[2];

endmodule
`default_nettype wire

// File: tb/tb_model_config_mem.sv
`default_nettype none
// ============================================================================
// tb_model_config_mem: scoreboard bench for model_config_mem.
// Revision: 1.0
// ============================================================================
module tb_model_config_mem;

    localparam int DEPTH = 64;
    localparam int RL    = 2;

    logic        clk_i   = 1'b0;
    logic        rst_ni  = 1'b0;
    logic [31:0] addr    = 32'd0;
    logic        valid   = 1'b0;
    logic [31:0] rdata;
    logic        rdy;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr  = 32'd0;
    logic [31:0] wr_data  = 32'd0;
    logic        wr_ready;
    logic [31:0] npu_cap, cim_cap, bubble;
`ifdef CONFIG_MEM_BOUNDS_CHECK_EN
    logic        rd_err;
`endif

    always #5 clk_i = ~clk_i;

    model_config_mem #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .clk_i                        (clk_i),
        .rst_ni                       (rst_ni),
        .config_mem_addr_i            (addr),
        .config_mem_read_valid_i      (valid),
        .config_mem_read_data_o       (rdata),
        .config_mem_read_ready_o      (rdy),
        .wr_valid_i                   (wr_valid),
        .wr_addr_i                    (wr_addr),
        .wr_data_i                    (wr_data),
        .wr_ready_o                   (wr_ready),
        .npu_capability_o             (npu_cap),
        .in_pipeline_cim_capability_o (cim_cap),
        .bubble_threshold_o           (bubble)
`ifdef CONFIG_MEM_BOUNDS_CHECK_EN
        ,
        .rd_err_o                     (rd_err)
`endif
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_fwd [DEPTH];
    logic [31:0] m_bwd [DEPTH];
    logic [31:0] m_cap [3];

    function automatic bit m_ok(input logic [31:0] a);
        if (a[31:10] != 0) return 1'b0;
        if (a[9:8] == 2'd0 || a[9:8] == 2'd1) return int'(a[7:0]) < DEPTH;
        if (a[9:8] == 2'd2) return int'(a[7:0]) <= 2;
        return 1'b0;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_fwd[i] = 32'd0;
            m_bwd[i] = 32'd0;
        end
        m_cap[0] = 32'd1;
        m_cap[1] = 32'd1;
        m_cap[2] = 32'd0;
    endfunction

    function automatic void m_write(input logic [31:0] a, input logic [31:0] d);
        if (m_ok(a)) begin
            if (a[9:8] == 2'd0) m_fwd[int'(a[7:0])] = d;
            else if (a[9:8] == 2'd1) m_bwd[int'(a[7:0])] = d;
            else m_cap[int'(a[7:0])] = d;
        end
    endfunction

    function automatic exp_t m_read(input logic [31:0] a);
        exp_t r;
        int   idx;
        idx    = int'(a[7:0]);
        r.err  = 1'b0;
        r.data = 32'd0;
`ifdef CONFIG_MEM_BOUNDS_CHECK_EN
        if (!m_ok(a)) begin
            r.err  = 1'b1;
            r.data = 32'hDEAD_BEEF;
            return r;
        end
`endif
        case (a[9:8])
            2'd0: r.data = m_fwd[idx % DEPTH];
            2'd1: r.data = m_bwd[idx % DEPTH];
            2'd2: r.data = (idx <= 2) ? m_cap[idx] : 32'd0;
            default: r.data = 32'd0;
        endcase
        return r;
    endfunction

    // Scoreboard: every ready pulse must match the oldest outstanding request.
    always @(negedge clk_i) begin
        if (rst_ni && rdy) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_ready: ready=1 data=%h, required no pulse", rdata);
            end else begin
                e = sb.pop_front();
                if (rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL sb_data: got %h required %h", rdata, e.data);
                end
`ifdef CONFIG_MEM_BOUNDS_CHECK_EN
                n_tests++;
                if (rd_err !== e.err) begin
                    n_fail++;
                    $display("FAIL sb_rd_err: got %b required %b", rd_err, e.err);
                end
`endif
            end
        end
    end

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_i);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(negedge clk_i);
        wr_valid = 1'b0;
        m_write(a, d);
    endtask

    task automatic read_word(input logic [31:0] a, input bit hold, input logic [31:0] a_after);
        int cyc;
        bit seen;
        @(negedge clk_i);
        addr  = a;
        valid = 1'b1;
        sb.push_back(m_read(a));
        @(posedge clk_i);
        #1;
        addr = a_after;
        if (!hold) valid = 1'b0;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk_i);
            cyc++;
            if (rdy) seen = 1'b1;
        end
        valid = 1'b0;
        n_tests++;
        if (!seen || cyc != RL) begin
            n_fail++;
            $display("FAIL read_latency addr=%h: got %0d cycles (seen=%0b) required %0d", a, cyc, seen, RL);
        end
        @(negedge clk_i);
        n_tests++;
        if (rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_single_pulse: got %b required 0", rdy);
        end
    endtask

    task automatic check_caps(input string tag, input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2);
        n_tests++;
        if (npu_cap !== c0 || cim_cap !== c1 || bubble !== c2) begin
            n_fail++;
            $display("FAIL %s caps: got %h/%h/%h required %h/%h/%h", tag, npu_cap, cim_cap, bubble, c0, c1, c2);
        end
    endtask

    task automatic test_reset();
        m_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        n_tests++;
        if (rdy !== 1'b0 || rdata !== 32'd0 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b data=%h wr_ready=%b required 0/0/0", rdy, rdata, wr_ready);
        end
        check_caps("reset", 32'd1, 32'd1, 32'd0);
`ifdef CONFIG_MEM_BOUNDS_CHECK_EN
        n_tests++;
        if (rd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rd_err: got %b required 0", rd_err);
        end
`endif
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_ready_after_reset: got %b required 1", wr_ready);
        end
    endtask

    task automatic test_basic();
        write_word(32'h003, 32'h10);
        read_word(32'h003, 1'b1, 32'h003);
    endtask

    task automatic test_caps();
        write_word(32'h105, 32'h22);
        @(negedge clk_i);
        wr_valid = 1'b1;
        wr_addr  = 32'h200;
        wr_data  = 32'd4;
        check_caps("cap_before_edge", 32'd1, 32'd1, 32'd0);
        @(negedge clk_i);
        wr_valid = 1'b0;
        m_write(32'h200, 32'd4);
        check_caps("cap_after_edge", 32'd4, 32'd1, 32'd0);
        write_word(32'h201, 32'h7);
        write_word(32'h202, 32'h9);
        check_caps("cap_all", 32'd4, 32'd7, 32'd9);
        read_word(32'h105, 1'b0, 32'h105);
        read_word(32'h200, 1'b0, 32'h200);
        read_word(32'h202, 1'b0, 32'h202);
    endtask

    task automatic test_addr_change();
        write_word(32'h00A, 32'hA5A5_0001);
        read_word(32'h00A, 1'b0, 32'h105);
    endtask

    task automatic test_back_to_back();
        int          pulses;
        int          cyc;
        int          last;
        logic [31:0] held;
        pulses = 0;
        cyc    = 0;
        last   = 0;
        held   = 32'd0;
        @(negedge clk_i);
        addr  = 32'h003;
        valid = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(m_read(32'h003));
        while (pulses < 3 && cyc < 60) begin
            @(negedge clk_i);
            cyc++;
            if (rdy) begin
                if (pulses > 0) begin
                    n_tests++;
                    if (cyc - last != RL + 1) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: got %0d required %0d", cyc - last, RL + 1);
                    end
                end
                last = cyc;
                held = rdata;
                pulses++;
                if (pulses == 3) valid = 1'b0;
            end else if (pulses > 0) begin
                n_tests++;
                if (rdata !== held) begin
                    n_fail++;
                    $display("FAIL b2b_data_stable: got %h required %h", rdata, held);
                end
            end
        end
        valid = 1'b0;
        n_tests++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL b2b_pulse_count: got %0d required 3", pulses);
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_collision();
        @(negedge clk_i);
        addr  = 32'h007;
        valid = 1'b1;
        sb.push_back(m_read(32'h007));
        if (RL == 1) begin
            wr_valid = 1'b1;
            wr_addr  = 32'h007;
            wr_data  = 32'h55;
        end
        @(posedge clk_i);
        #1;
        valid    = 1'b0;
        wr_valid = 1'b0;
        for (int i = 1; i < RL; i++) @(negedge clk_i);
        if (RL > 1) begin
            wr_valid = 1'b1;
            wr_addr  = 32'h007;
            wr_data  = 32'h55;
            @(negedge clk_i);
            wr_valid = 1'b0;
        end
        n_tests++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_ready: got %b required 1", rdy);
        end
        m_write(32'h007, 32'h55);
        @(negedge clk_i);
        read_word(32'h007, 1'b0, 32'h007);
    endtask

    task automatic test_out_of_range();
        write_word(32'h001, 32'hA1);
        write_word(32'h043, 32'hBAD0_0001);
        write_word(32'h403, 32'hBAD0_0002);
        write_word(32'h203, 32'hBAD0_0003);
        write_word(32'h300, 32'hBAD0_0004);
        check_caps("oor_writes", 32'd4, 32'd7, 32'd9);
        read_word(32'h003, 1'b0, 32'h003);
        read_word(32'h041, 1'b0, 32'h041);
        read_word(32'h300, 1'b0, 32'h300);
        read_word(32'h2FF, 1'b0, 32'h2FF);
        read_word(32'h403, 1'b0, 32'h403);
        read_word(32'h001, 1'b0, 32'h001);
    endtask

    task automatic test_reset_mid_read();
        bit bad_ready;
        @(negedge clk_i);
        addr  = 32'h003;
        valid = 1'b1;
        @(posedge clk_i);
        #1;
        valid = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        m_reset();
        bad_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (rdy !== 1'b0) bad_ready = 1'b1;
        end
        n_tests++;
        if (bad_ready || rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_read: ready_seen=%b data=%h required 0/0", bad_ready, rdata);
        end
        check_caps("reset_mid_read", 32'd1, 32'd1, 32'd0);
        read_word(32'h003, 1'b0, 32'h003);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_caps();
        test_addr_change();
        test_back_to_back();
        test_collision();
        test_out_of_range();
        test_reset_mid_read();
        repeat (3) @(negedge clk_i);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d outstanding required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/model_config_mem.md
MODEL_CONFIG_MEM -- requirements
Module: model_config_mem

Interface
REQ-001 Parameter: DEPTH, 64, entries per compute table (power of two, 2..256).
REQ-002 Parameter: READ_LATENCY, 2, cycles from read acceptance to ready pulse (1..15).
REQ-003 clk_i  input  1  clock; all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 config_mem_addr_i  input  32  read address: [9:8] region, [7:0] index, [31:10] must be zero.
REQ-006 config_mem_read_valid_i  input  1  read request, level-held by initiator.
REQ-007 config_mem_read_data_o  output  32  read data.
REQ-008 config_mem_read_ready_o  output  1  one-cycle pulse: read_data_o valid.
REQ-009 wr_valid_i  input  1  host write strobe, one write per cycle.
REQ-010 wr_addr_i  input  32  write address, same map as read.
REQ-011 wr_data_i  input  32  write data.
REQ-012 wr_ready_o  output  1  tied high after reset release; low during reset.
REQ-013 npu_capability_o  output  32  capability register 0.
REQ-014 in_pipeline_cim_capability_o  output  32  capability register 1.
REQ-015 bubble_threshold_o  output  32  capability register 2.
REQ-016 rd_err_o  output  1  present only with CONFIG_MEM_BOUNDS_CHECK_EN; high with ready pulse of an out-of-range read.

Function
REQ-017 Region map: 0 forward compute table, 1 backward compute table, 2 capability registers (index 0/1/2 as REQ-013..015), 3 reserved.
REQ-018 Read FSM states IDLE, WAIT, RESP; IDLE->WAIT when read_valid_i=1 (acceptance, address latched); WAIT->RESP when latency counter reaches READ_LATENCY-1; RESP->IDLE unconditionally.
REQ-019 READ_LATENCY=1: IDLE->RESP directly; WAIT skipped.
REQ-020 Acceptance in cycle T gives ready_o=1 in exactly cycle T+READ_LATENCY, for one cycle only.
REQ-021 read_data_o is registered on entry to RESP from the latched address and holds stable until the next RESP; it does not change in IDLE or WAIT.
REQ-022 read_valid_i sampled high in the cycle after RESP starts a new read (back-to-back throughput = one read per READ_LATENCY+1 cycles).
REQ-023 read_valid_i dropping after acceptance does not abort the read; the response is still issued.
REQ-024 Address changes after acceptance are ignored until the next acceptance.
REQ-025 Writes take effect at the clock edge where wr_valid_i=1; writes to region 3, index >= DEPTH (regions 0/1), index > 2 (region 2), or nonzero [31:10] are discarded.
REQ-026 Write and data capture to the same location in the same cycle: read returns the pre-write value.
REQ-027 Capability outputs are direct register outputs, updated the cycle after the write edge.
REQ-028 Out-of-range read without bounds check: regions 0/1 index taken modulo DEPTH; region 2 index > 2 and region 3 return 0; [31:10] ignored.

Reset
REQ-029 On rst_ni low: FSM IDLE, counter 0, ready_o 0, read_data_o 0, rd_err_o 0, both tables 0, npu_capability 1, in_pipeline_cim_capability 1, bubble_threshold 0.
REQ-030 Reset asserted mid-read drops the pending response; no ready pulse follows reset release unless a new request is accepted.

Configuration
REQ-031 Macro CONFIG_MEM_BOUNDS_CHECK_EN defined: any read violating REQ-025 limits returns 32'hDEAD_BEEF with rd_err_o=1 in the ready cycle; rd_err_o 0 otherwise.
REQ-032 Macro undefined: rd_err_o port absent; out-of-range reads behave per REQ-028; latency unchanged either way.

Verification
REQ-033 Write forward[3]=0x10, hold read_valid with addr 0x003, READ_LATENCY=2 -> ready high exactly 2 cycles after acceptance, data 0x10, ready low next cycle.
REQ-034 Write backward[5]=0x22 and npu_capability=4 -> read 0x105 returns 0x22; npu_capability_o reads 4 the cycle after the write.
REQ-035 valid held high continuously, 3 reads -> ready pulses spaced READ_LATENCY+1 cycles, data stable between pulses.
REQ-036 Read addr 0x007 accepted, write forward[7]=0x55 on capture edge -> returns old value 0; next read returns 0x55.
REQ-037 Assert rst_ni during WAIT -> ready stays 0, data 0, capabilities 1/1/0 after release.
REQ-038 With CONFIG_MEM_BOUNDS_CHECK_EN read 0x300 -> data 0xDEAD_BEEF, rd_err_o=1; without macro, DEPTH=64, read 0x041 -> returns forward[1].
